pipe_perf_mon: RTL
==================

# pipe_perf_mon

Synthesizable hazard/performance monitor for the 5-stage pipeline CPU. It counts per-cycle pipeline events such as stall, branch taken, forwardA/B active and IF/ID or ID/EX flush, plus a free-running cycle count. Counter width, channel count and overflow mode are parameters. Counters are read through a registered select/data port, and an optional trace FIFO records timestamped event vectors. It sits beside `comp`'s CPU, is fed from the hazard/forwarding unit outputs, and is readable by benches or a debug bus without hierarchical peeking.

## Interface
Parameters:
- `NUM_EVT`, default 6: number of event channels (1..31).
- `CNT_W`, default 32: width of every counter (8..64).
- `SAT`, default 0: overflow mode. 0 = wrap, 1 = saturate.
- `TRACE_DEPTH`, default 16: trace FIFO entries. Must be a power of 2, 2..256. Used only with `PERF_TRACE_EN`.

Ports:
- `clk`  in  1: clock.
- `rstn`  in  1: reset, synchronous, active-low.
- `en_i`  in  1: count enable. When low, all counters and the trace freeze.
- `clr_i`  in  1: synchronous clear of all counters and overflow flags.
- `evt_i`  in  `NUM_EVT`: per-cycle event strobes. Bit i = event i asserted this cycle.
- `sel_i`  in  5: read select. 0 = cycle counter; 1..`NUM_EVT` = event counter `sel_i-1`; any other value reads 0.
- `rd_data_o`  out  `CNT_W`: registered read data.
- `ovf_o`  out  `NUM_EVT+1`: sticky overflow flags. Bit 0 = cycle counter; bit i+1 = event i.
- `trace_pop_i`  in  1: consume the trace head entry.
- `trace_valid_o`  out  1: trace FIFO non-empty.
- `trace_data_o`  out  `16+NUM_EVT`: head entry, {timestamp[15:0], evt vector}. Show-ahead.
- `trace_drop_o`  out  1: sticky flag, set when at least one trace entry was dropped.

## Operation
- **Reset** (`rstn`=0 at a rising edge) drives every output to 0:
  - all counters and `rd_data_o`;
  - `ovf_o`;
  - FIFO pointers and count, so `trace_valid_o`=0;
  - `trace_data_o` and `trace_drop_o`.
  - Reset overrides all other inputs, including mid-burst pushes or pops.
- **Cycle counter:** when `en_i`=1 and `clr_i`=0, increments by 1 every cycle.
- **Event counter i:** when `en_i`=1, `clr_i`=0 and `evt_i[i]`=1, increments by 1. Simultaneous events increment their counters independently, all in the same cycle.
- **`clr_i`** has priority over increment. On that edge all counters and `ovf_o` go to 0, and the events of that cycle are not counted. Trace FIFO contents and `trace_drop_o` are unaffected.
- **Overflow with `SAT`=0:** an increment from all-ones wraps the counter to 0 and sets its `ovf_o` bit.
- **Overflow with `SAT`=1:** an increment at all-ones holds the counter at all-ones and sets its `ovf_o` bit.
- `ovf_o` bits stay set until `clr_i` or reset.
- **Read path:** `rd_data_o` <= counter[`sel_i`], sampled at the edge. It returns the counter value *before* that edge's increment.
- **Trace:** a push is attempted when `en_i`=1 and `evt_i` is nonzero. The entry is {cycle_counter[15:0], `evt_i`}, using the timestamp value before the increment.
  - The push is accepted if the FIFO is not full, or if it is full and a valid pop occurs in the same cycle.
  - Otherwise the entry is dropped and `trace_drop_o` is set.
  - A pop while empty is ignored.
  - Simultaneous push and pop leaves the occupancy unchanged.
  - Pointers wrap modulo `TRACE_DEPTH`.

## Timing
- Event on evt_i at edge N: the counter shows +1 after edge N. Selecting that counter at edge N+1 puts the updated value on `rd_data_o` after N+1, giving 2-cycle event-to-read latency.
- `sel_i` to `rd_data_o` latency: 1 cycle.
- Push at edge N: `trace_valid_o` is 1 after N, with zero bubble.
- Pop at edge N: the next entry is on `trace_data_o` after N. If the FIFO is now empty, `trace_valid_o` falls after N.
- `ovf_o` is set at the same edge as the wrap or saturate.
- No combinational path from any input to any output.

## Configuration
- `PERF_TRACE_EN` defined: trace FIFO, timestamp capture and `trace_drop_o` are built, behaving as described above.
- `PERF_TRACE_EN` undefined:
  - no FIFO storage is instantiated;
  - `trace_valid_o`, `trace_data_o` and `trace_drop_o` are tied to 0;
  - `trace_pop_i` is ignored;
  - counters behave identically.

## Test plan
- **Basic counting:** reset, then `en_i`=1, with `evt_i`=6'b000001 for 10 cycles and then 0 for 5 cycles. Expect sel 0 to read 15, sel 1 to read 10 and sel 2 to read 0, with each read appearing 1 cycle after `sel_i`.
- **Wrap and saturate:** `CNT_W`=8, event 0 held for 257 cycles.
  - `SAT`=0: counter reads 1 and `ovf_o[1]`=1.
  - `SAT`=1: counter reads 255 and `ovf_o[1]`=1.
  - Cycle counter bit `ovf_o[0]` is set in both cases.
- **Clear vs. increment:** `clr_i`=1 on the same cycle as `evt_i`=all-ones. Afterwards all counters and `ovf_o` read 0. The next enabled cycle makes the cycle counter 1.
- **Trace full/drop:** `PERF_TRACE_EN`, `TRACE_DEPTH`=4, events on cycles 0..5 with no pop.
  - Expect 4 entries with timestamps 0..3 and `trace_drop_o`=1.
  - Then push and pop together while full: the entry with timestamp 0 is consumed, the new entry is accepted and occupancy stays 4.
- **Freeze and reset mid-run:** drop `en_i` for 7 cycles while events continue; expect counters and trace unchanged. Then assert `rstn`=0 for 1 cycle while the FIFO is non-empty; expect all outputs 0 on the following cycle.
- **Macro off:** without `PERF_TRACE_EN`, events plus `trace_pop_i`=1. Expect trace outputs constant 0 and counters matching the first scenario.

Source files
------------

// File: rtl/pipe_perf_mon.sv
`default_nettype none
// ============================================================================
// Module      : pipe_perf_mon
// Description : Pipeline hazard/performance monitor: free-running cycle
//               counter, per-event counters with wrap/saturate overflow,
//               registered read port and an optional timestamped trace FIFO
//               (built when PERF_TRACE_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_perf_mon #(
    parameter int NUM_EVT     = 6,
    parameter int CNT_W       = 32,
    parameter int SAT         = 0,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [NUM_EVT-1:0]    evt_i,
    input  logic [4:0]            sel_i,
    output logic [CNT_W-1:0]      rd_data_o,
    output logic [NUM_EVT:0]      ovf_o,
    input  logic                  trace_pop_i,
    output logic                  trace_valid_o,
    output logic [16+NUM_EVT-1:0] trace_data_o,
    output logic                  trace_drop_o
);

    localparam int c_NUM_CNT = NUM_EVT + 1;

    // Index 0 is the cycle counter, index i+1 is event i.
    logic [CNT_W-1:0]     w_cnt [c_NUM_CNT];
    logic [c_NUM_CNT-1:0] w_ovf;
    logic [c_NUM_CNT-1:0] w_inc;
    logic [CNT_W-1:0]     w_rd;
    logic [CNT_W-1:0]     r_rd_data;

    assign w_inc = (en_i && !clr_i) ? {evt_i, 1'b1} : '0;

    for (genvar g = 0; g < c_NUM_CNT; g++) begin : g_cnt
        logic [CNT_W-1:0] r_val;
        logic             r_of;

        always_ff @(posedge clk) begin
            if (!rstn) begin
                r_val <= '0;
                r_of  <= 1'b0;
            end else if (clr_i) begin
                r_val <= '0;
                r_of  <= 1'b0;
            end else if (w_inc[g]) begin
                if (&r_val) begin
                    r_of  <= 1'b1;
                    r_val <= (SAT != 0) ? r_val : '0;
                end else begin
                    r_val <= r_val + 1'b1;
                end
            end
        end

        assign w_cnt[g] = r_val;
        assign w_ovf[g] = r_of;
    end

    always_comb begin
        w_rd = '0;
        for (int k = 0; k < c_NUM_CNT; k++) begin
            if (sel_i == k[4:0]) begin
                w_rd = w_cnt[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd;
        end
    end

    assign rd_data_o = r_rd_data;
    assign ovf_o     = w_ovf;

`ifdef PERF_TRACE_EN
    localparam int                  c_AW   = $clog2(TRACE_DEPTH);
    localparam int                  c_TW   = 16 + NUM_EVT;
    localparam logic [c_AW:0]       c_FULL = (c_AW + 1)'(TRACE_DEPTH);

    logic [c_TW-1:0] r_mem [TRACE_DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_AW:0]   r_count;
    logic            r_drop;
    logic [15:0]     w_ts;
    logic            w_full;
    logic            w_empty;
    logic            w_pop_ok;
    logic            w_push_try;
    logic            w_push_ok;

    if (CNT_W >= 16) begin : g_ts_wide
        assign w_ts = w_cnt[0][15:0];
    end else begin : g_ts_narrow
        assign w_ts = {{(16 - CNT_W){1'b0}}, w_cnt[0]};
    end

    assign w_full     = (r_count == c_FULL);
    assign w_empty    = (r_count == '0);
    // Pops are frozen along with everything else while the monitor is disabled.
    assign w_pop_ok   = en_i && trace_pop_i && !w_empty;
    assign w_push_try = en_i && (|evt_i);
    assign w_push_ok  = w_push_try && (!w_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_drop  <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - 1'b1;
            end
            if (w_push_try && !w_push_ok) begin
                r_drop <= 1'b1;
            end
        end
    end

    // Storage is not reset; the empty gate on the output keeps reset values at 0.
    always_ff @(posedge clk) begin
        if (rstn && w_push_ok) begin
            r_mem[r_wptr] <= {w_ts, evt_i};
        end
    end

    assign trace_valid_o = !w_empty;
    assign trace_data_o  = w_empty ? '0 : r_mem[r_rptr];
    assign trace_drop_o  = r_drop;
`else
    localparam int c_unused_depth = TRACE_DEPTH;
    logic          w_unused_pop;

    assign w_unused_pop  = trace_pop_i;
    assign trace_valid_o = 1'b0;
    assign trace_data_o  = '0;
    assign trace_drop_o  = 1'b0;
`endif

endmodule
`default_nettype wire
